// File: rtl/sprite_arb_pkg.sv
// Shared types and constants for the sprite ROM arbiter.
// Optional feature macro used by the arbiter: SPRITE_TRANSP_FALLBACK_EN.
package sprite_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 21;
    localparam int DATA_W = 4;
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [DATA_W-1:0] TRANSP = '0;

    typedef logic [ID_W-1:0] id_t;

    // One stage of the grant-identity pipeline that travels beside the ROM.
    typedef struct packed {
        logic v0;
        id_t  id0;
        logic v1;
        id_t  id1;
    } tag_t;

    // True when two or more bits are set (clearing the lowest set bit leaves something).
    function automatic logic at_least_two(input logic [N_REQ-1:0] v);
        return |(v & (v - 1'b1));
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Bus bundle between animation units, sprite ROM, colour mapper and the arbiter.
// slave: arbiter side. master: the environment driving requests and ROM data.
interface sprite_rom_arbiter_if import sprite_arb_pkg::*;;

    logic [N_REQ-1:0]        req_on;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0]       rom_addr_a;
    logic [ADDR_W-1:0]       rom_addr_b;
    logic                    rom_ce;
    logic [DATA_W-1:0]       rom_q_a;
    logic [DATA_W-1:0]       rom_q_b;
    logic                    pix_valid;
    id_t                     pix_layer;
    logic [DATA_W-1:0]       pix_color;
    logic [N_REQ-1:0]        overlap_mask;
    logic [15:0]             overlap_cnt;

    modport slave (
        input  req_on, req_addr, rom_q_a, rom_q_b,
        output rom_addr_a, rom_addr_b, rom_ce,
        output pix_valid, pix_layer, pix_color, overlap_mask, overlap_cnt
    );

    modport master (
        output req_on, req_addr, rom_q_a, rom_q_b,
        input  rom_addr_a, rom_addr_b, rom_ce,
        input  pix_valid, pix_layer, pix_color, overlap_mask, overlap_cnt
    );

endinterface

// File: rtl/sprite_prio_enc.sv
// Combinational priority encoder: lowest and next-lowest set bit of req_on.
module sprite_prio_enc import sprite_arb_pkg::*; (
    input  logic [N_REQ-1:0] req_on,
    output logic             g0_v,
    output id_t              g0,
    output logic             g1_v,
    output id_t              g1
);

    logic [N_REQ-1:0] rest;

    // Scan downward so the lowest active index is the last one written.
    always_comb begin
        g0_v = 1'b0;
        g0   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_on[i]) begin
                g0_v = 1'b1;
                g0   = id_t'(i);
            end
        end
    end

    // Same scan with the first winner removed gives the runner-up.
    always_comb begin
        rest = req_on;
        if (g0_v) begin
            rest[g0] = 1'b0;
        end
        g1_v = 1'b0;
        g1   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rest[i]) begin
                g1_v = 1'b1;
                g1   = id_t'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: grants the shared ROM to the highest-priority active
// requester each pixel, carries the grant identity alongside the ROM latency,
// emits the layered colour index and collects per-frame overlap statistics.
// Optional feature: define SPRITE_TRANSP_FALLBACK_EN to let the second-priority
// requester show through transparent pixels of the first via ROM port B.
module sprite_rom_arbiter import sprite_arb_pkg::*; #(
    parameter int ROM_LAT = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 pix_ce,
    input  logic                 frame_start,
    sprite_rom_arbiter_if.slave  bus
);

    logic             g0_v, g1_v;
    id_t              g0, g1;
    logic [ADDR_W-1:0] addr_arr [N_REQ];

    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    tag_t              tag_d;
    tag_t              tag_q [ROM_LAT+1];
    tag_t              tag_al;

    logic              pix_valid_q, pix_valid_d;
    id_t               pix_layer_q, pix_layer_d;
    logic [DATA_W-1:0] pix_color_q, pix_color_d;

    logic [N_REQ-1:0]  mask_contrib;
    logic              cnt_hit;
    logic [N_REQ-1:0]  acc_mask_q, acc_mask_d;
    logic [15:0]       acc_cnt_q, acc_cnt_d;
    logic [N_REQ-1:0]  overlap_mask_q, overlap_mask_d;
    logic [15:0]       overlap_cnt_q, overlap_cnt_d;

    sprite_prio_enc u_enc (
        .req_on (bus.req_on),
        .g0_v   (g0_v),
        .g0     (g0),
        .g1_v   (g1_v),
        .g1     (g1)
    );

    // Unpack the flat address bus into one entry per requester.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
        assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
    end

    // Next address and tag for this pixel; an idle grant drives address 0.
    always_comb begin
        addr_a_d  = g0_v ? addr_arr[g0] : '0;
        addr_b_d  = '0;
        tag_d     = '0;
        tag_d.v0  = g0_v;
        tag_d.id0 = g0;
`ifdef SPRITE_TRANSP_FALLBACK_EN
        addr_b_d  = g1_v ? addr_arr[g1] : '0;
        tag_d.v1  = g1_v;
        tag_d.id1 = g1;
`endif
    end

    // Address registers and the tag shift register, frozen while pix_ce is low.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (pix_ce) begin
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tag_q[0] <= tag_d;
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // The last tag stage lines up with the data now on rom_q_a/b.
    assign tag_al = tag_q[ROM_LAT];

    // Pick the visible pixel: primary if opaque, else (optionally) the runner-up.
    always_comb begin
        pix_valid_d = 1'b0;
        pix_layer_d = '0;
        pix_color_d = TRANSP;
        if (tag_al.v0 && (bus.rom_q_a != TRANSP)) begin
            pix_valid_d = 1'b1;
            pix_layer_d = tag_al.id0;
            pix_color_d = bus.rom_q_a;
        end
`ifdef SPRITE_TRANSP_FALLBACK_EN
        else if (tag_al.v1 && (bus.rom_q_b != TRANSP)) begin
            pix_valid_d = 1'b1;
            pix_layer_d = tag_al.id1;
            pix_color_d = bus.rom_q_b;
        end
`endif
    end

    // Registered pixel output towards the colour mapper.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_valid_q <= 1'b0;
            pix_layer_q <= '0;
            pix_color_q <= TRANSP;
        end else if (pix_ce) begin
            pix_valid_q <= pix_valid_d;
            pix_layer_q <= pix_layer_d;
            pix_color_q <= pix_color_d;
        end
    end

    // Per-pixel overlap contribution: who shares the pixel with the player.
    assign mask_contrib = {bus.req_on[N_REQ-1:1] & {(N_REQ-1){bus.req_on[0]}}, 1'b0};
    assign cnt_hit      = at_least_two(bus.req_on);

    // On frame_start publish the finished frame and restart with this pixel only.
    always_comb begin
        overlap_mask_d = overlap_mask_q;
        overlap_cnt_d  = overlap_cnt_q;
        if (frame_start) begin
            overlap_mask_d = acc_mask_q;
            overlap_cnt_d  = acc_cnt_q;
            acc_mask_d     = mask_contrib;
            acc_cnt_d      = {15'd0, cnt_hit};
        end else begin
            acc_mask_d     = acc_mask_q | mask_contrib;
            acc_cnt_d      = (cnt_hit && (acc_cnt_q != 16'hFFFF)) ? acc_cnt_q + 16'd1 : acc_cnt_q;
        end
    end

    // Accumulator and published-result registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_mask_q     <= '0;
            acc_cnt_q      <= '0;
            overlap_mask_q <= '0;
            overlap_cnt_q  <= '0;
        end else if (pix_ce) begin
            acc_mask_q     <= acc_mask_d;
            acc_cnt_q      <= acc_cnt_d;
            overlap_mask_q <= overlap_mask_d;
            overlap_cnt_q  <= overlap_cnt_d;
        end
    end

    assign bus.rom_ce       = pix_ce;
    assign bus.rom_addr_a   = addr_a_q;
`ifdef SPRITE_TRANSP_FALLBACK_EN
    assign bus.rom_addr_b   = addr_b_q;
`else
    assign bus.rom_addr_b   = '0;
`endif
    assign bus.pix_valid    = pix_valid_q;
    assign bus.pix_layer    = pix_layer_q;
    assign bus.pix_color    = pix_color_q;
    assign bus.overlap_mask = overlap_mask_q;
    assign bus.overlap_cnt  = overlap_cnt_q;

    // Signals that only matter when the fallback path is built.
    logic unused_fallback;
    assign unused_fallback = ^{bus.rom_q_b, tag_al.v1, tag_al.id1, addr_b_q, g1_v, g1};

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed testbench for sprite_rom_arbiter with a 2-cycle ROM model.
module tb_sprite_rom_arbiter;
    import sprite_arb_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n;
    logic pix_ce;
    logic frame_start;
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] ra1 = '0, rb1 = '0, rq_a = '0, rq_b = '0;

    always #5 Clk = ~Clk;

    sprite_rom_arbiter_if bus ();

    sprite_rom_arbiter #(.ROM_LAT(2)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pix_ce      (pix_ce),
        .frame_start (frame_start),
        .bus         (bus)
    );

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        case (a)
            21'd5000: return 4'd7;
            21'd100:  return 4'd5;
            21'd200:  return 4'd9;
            21'd300:  return 4'd0;
            21'd400:  return 4'd3;
            default:  return a[3:0];
        endcase
    endfunction

    // ROM model: two enabled cycles from address to data.
    always @(posedge Clk) begin
        if (bus.rom_ce) begin
            ra1  <= rom_fn(bus.rom_addr_a);
            rb1  <= rom_fn(bus.rom_addr_b);
            rq_a <= ra1;
            rq_b <= rb1;
        end
    end
    assign bus.rom_q_a = rq_a;
    assign bus.rom_q_b = rq_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    initial begin
        Reset_n     = 1'b0;
        pix_ce      = 1'b1;
        frame_start = 1'b0;
        bus.req_on  = '0;
        bus.req_addr = '0;
        tick(3);
        chk("rst_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_layer", 32'(bus.pix_layer), 32'd0);
        chk("rst_color", 32'(bus.pix_color), 32'd0);
        chk("rst_addr_a", 32'(bus.rom_addr_a), 32'd0);
        chk("rst_addr_b", 32'(bus.rom_addr_b), 32'd0);
        chk("rst_mask", 32'(bus.overlap_mask), 32'd0);
        chk("rst_cnt", 32'(bus.overlap_cnt), 32'd0);
        chk("rst_rom_ce", 32'(bus.rom_ce), 32'd1);
        Reset_n = 1'b1;
        tick(2);

        // Single requester 2 at address 5000, ROM returns 7.
        set_addr(2, 21'd5000);
        bus.req_on = 4'b0100;
        tick(1);
        chk("t1_addr_a", 32'(bus.rom_addr_a), 32'd5000);
        chk("t1_addr_b", 32'(bus.rom_addr_b), 32'd0);
        bus.req_on = 4'b0000;
        tick(2);
        chk("t1_early_valid", 32'(bus.pix_valid), 32'd0);
        tick(1);
        chk("t1_valid", 32'(bus.pix_valid), 32'd1);
        chk("t1_layer", 32'(bus.pix_layer), 32'd2);
        chk("t1_color", 32'(bus.pix_color), 32'd7);
        tick(1);
        chk("t1_after_valid", 32'(bus.pix_valid), 32'd0);

        // Requesters 0 and 2 together: 0 wins port A.
        set_addr(0, 21'd100);
        set_addr(2, 21'd200);
        bus.req_on = 4'b0101;
        tick(1);
        chk("t2_addr_a", 32'(bus.rom_addr_a), 32'd100);
`ifdef SPRITE_TRANSP_FALLBACK_EN
        chk("t2_addr_b", 32'(bus.rom_addr_b), 32'd200);
`else
        chk("t2_addr_b", 32'(bus.rom_addr_b), 32'd0);
`endif
        bus.req_on = 4'b0000;
        tick(3);
        chk("t2_valid", 32'(bus.pix_valid), 32'd1);
        chk("t2_layer", 32'(bus.pix_layer), 32'd0);
        chk("t2_color", 32'(bus.pix_color), 32'd5);

        // Requester 0 transparent, requester 2 opaque colour 3.
        set_addr(0, 21'd300);
        set_addr(2, 21'd400);
        bus.req_on = 4'b0101;
        tick(1);
        bus.req_on = 4'b0000;
        tick(3);
`ifdef SPRITE_TRANSP_FALLBACK_EN
        chk("t3_valid", 32'(bus.pix_valid), 32'd1);
        chk("t3_layer", 32'(bus.pix_layer), 32'd2);
        chk("t3_color", 32'(bus.pix_color), 32'd3);
`else
        chk("t3_valid", 32'(bus.pix_valid), 32'd0);
        chk("t3_layer", 32'(bus.pix_layer), 32'd0);
        chk("t3_color", 32'(bus.pix_color), 32'd0);
`endif

        // Requesters 1 and 3: grant order skips the idle player slot.
        set_addr(1, 21'd1111);
        set_addr(3, 21'd3333);
        bus.req_on = 4'b1010;
        tick(1);
        chk("t4_addr_a", 32'(bus.rom_addr_a), 32'd1111);
`ifdef SPRITE_TRANSP_FALLBACK_EN
        chk("t4_addr_b", 32'(bus.rom_addr_b), 32'd3333);
`else
        chk("t4_addr_b", 32'(bus.rom_addr_b), 32'd0);
`endif
        bus.req_on = 4'b0000;
        tick(4);

        // Partial frame since reset: 0101 twice and 1010 once.
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("f0_mask", 32'(bus.overlap_mask), 32'h4);
        chk("f0_cnt", 32'(bus.overlap_cnt), 32'd3);

        // Full frame: 10 x 1001, 5 x 0110; closing frame_start pixel is counted next frame.
        bus.req_on = 4'b1001;
        tick(10);
        bus.req_on = 4'b0110;
        tick(5);
        bus.req_on = 4'b0011;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("f1_mask", 32'(bus.overlap_mask), 32'h8);
        chk("f1_cnt", 32'(bus.overlap_cnt), 32'd15);
        bus.req_on = 4'b1100;
        tick(2);
        bus.req_on = 4'b0000;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("f2_mask", 32'(bus.overlap_mask), 32'h2);
        chk("f2_cnt", 32'(bus.overlap_cnt), 32'd3);
        tick(4);

        // Stall with a pixel in flight; unqualified frame_start is ignored.
        set_addr(2, 21'd5000);
        bus.req_on = 4'b0100;
        tick(1);
        chk("s_addr_a", 32'(bus.rom_addr_a), 32'd5000);
        bus.req_on = 4'b0000;
        pix_ce = 1'b0;
        frame_start = 1'b1;
        tick(5);
        chk("s_addr_frozen", 32'(bus.rom_addr_a), 32'd5000);
        chk("s_rom_ce", 32'(bus.rom_ce), 32'd0);
        chk("s_valid_frozen", 32'(bus.pix_valid), 32'd0);
        chk("s_cnt_frozen", 32'(bus.overlap_cnt), 32'd3);
        frame_start = 1'b0;
        pix_ce = 1'b1;
        tick(2);
        chk("s_early_valid", 32'(bus.pix_valid), 32'd0);
        tick(1);
        chk("s_valid", 32'(bus.pix_valid), 32'd1);
        chk("s_color", 32'(bus.pix_color), 32'd7);
        pix_ce = 1'b0;
        tick(3);
        chk("s_hold_valid", 32'(bus.pix_valid), 32'd1);
        chk("s_hold_color", 32'(bus.pix_color), 32'd7);
        pix_ce = 1'b1;
        tick(1);
        chk("s_after_valid", 32'(bus.pix_valid), 32'd0);

        // Asynchronous reset mid-frame with traffic in flight.
        bus.req_on = 4'b0011;
        tick(3);
        set_addr(2, 21'd5000);
        bus.req_on = 4'b0100;
        tick(1);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.pix_valid), 32'd0);
        chk("ar_color", 32'(bus.pix_color), 32'd0);
        chk("ar_addr_a", 32'(bus.rom_addr_a), 32'd0);
        chk("ar_mask", 32'(bus.overlap_mask), 32'd0);
        chk("ar_cnt", 32'(bus.overlap_cnt), 32'd0);
        #2;
        Reset_n = 1'b1;
        bus.req_on = 4'b1001;
        tick(4);
        bus.req_on = 4'b0000;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("ar_f_mask", 32'(bus.overlap_mask), 32'h8);
        chk("ar_f_cnt", 32'(bus.overlap_cnt), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
